// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers for the
// EXE stage of the pipelined MIPS core. One operation runs at a time; busy
// stays high for MULT_LAT or DIV_LAT cycles, then {hi, lo} is written.
// Optional feature macro: MD_DIV_EN -- when defined, DIV/DIVU are built;
// when undefined, no divider exists and DIV/DIVU starts are ignored.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MD_DIV_EN
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
`else
    localparam int MAX_LAT = MULT_LAT;
`endif
    localparam int CNT_W = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MULT_LAT);
`ifdef MD_DIV_EN
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   load_s;
    logic               op_ok_s;
    logic               accept_s;
    logic               busy_r;
    logic               busy_n;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;

    // Latched operation: operands plus the signed/unsigned flag.
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               op_signed_r;
`ifdef MD_DIV_EN
    logic               op_div_r;
`endif

    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
`ifdef MD_DIV_EN
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   quo_u_s;
    logic [WIDTH-1:0]   rem_u_s;
`endif

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Decide whether the requested op exists in this build and pick its latency.
    always_comb begin
        op_ok_s = 1'b1;
        load_s  = CNT_MUL;
`ifdef MD_DIV_EN
        if (md_op[1]) begin
            load_s = CNT_DIV;
        end else begin
            load_s = CNT_MUL;
        end
`else
        op_ok_s = ~md_op[1];
`endif
    end

    // Result datapath from the latched operands (never from live a/b).
    always_comb begin
        // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
        // product are then correct for both MULT and MULTU.
        ext_a_s  = {{WIDTH{op_signed_r & a_r[WIDTH-1]}}, a_r};
        ext_b_s  = {{WIDTH{op_signed_r & b_r[WIDTH-1]}}, b_r};
        prod_s   = ext_a_s * ext_b_s;
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MD_DIV_EN
        // Signed divide on magnitudes, then restore signs: quotient negative
        // when signs differ, remainder follows the dividend.
        neg_a_s  = op_signed_r & a_r[WIDTH-1];
        neg_b_s  = op_signed_r & b_r[WIDTH-1];
        mag_a_s  = neg_a_s ? (ZERO_W - a_r) : a_r;
        mag_b_s  = neg_b_s ? (ZERO_W - b_r) : b_r;
        quo_u_s  = ZERO_W;
        rem_u_s  = ZERO_W;
        if (op_div_r) begin
            if (b_r == ZERO_W) begin
                res_lo_s = ONES_W;
                res_hi_s = a_r;
            end else if (op_signed_r && (a_r == MOST_NEG) && (b_r == ONES_W)) begin
                res_lo_s = a_r;
                res_hi_s = ZERO_W;
            end else begin
                quo_u_s  = mag_a_s / mag_b_s;
                rem_u_s  = mag_a_s % mag_b_s;
                res_lo_s = (neg_a_s ^ neg_b_s) ? (ZERO_W - quo_u_s) : quo_u_s;
                res_hi_s = neg_a_s ? (ZERO_W - rem_u_s) : rem_u_s;
            end
        end else begin
            res_lo_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Next-state logic: accept in IDLE, count down in RUN, write HI/LO at 1.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        accept_s = 1'b0;
        hi_n     = hi_r;
        lo_n     = lo_r;
        case (state_r)
            IDLE: begin
                if (start && op_ok_s) begin
                    // A start wins over MTHI/MTLO in the same cycle.
                    accept_s = 1'b1;
                    state_n  = RUN;
                    cnt_n    = load_s;
                end else begin
                    if (we_hi) begin
                        hi_n = a;
                    end else begin
                        hi_n = hi_r;
                    end
                    if (we_lo) begin
                        lo_n = a;
                    end else begin
                        lo_n = lo_r;
                    end
                end
            end
            RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                    hi_n    = res_hi_s;
                    lo_n    = res_lo_s;
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase
        busy_n = (state_n == RUN);
    end

    // State, counter, busy flag and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
        end
    end

    // Operand capture at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= ZERO_W;
            b_r         <= ZERO_W;
            op_signed_r <= 1'b0;
`ifdef MD_DIV_EN
            op_div_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r         <= a;
            b_r         <= b;
            op_signed_r <= ~md_op[0];
`ifdef MD_DIV_EN
            op_div_r    <= md_op[1];
`endif
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (WIDTH=32, MULT_LAT=5, DIV_LAT=10).
// Expected values come from a plain-arithmetic model of MIPS MULT/DIV rules.
// Honours MD_DIV_EN the same way as the design.
module tb_md_unit;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   md_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         we_hi;
    logic         we_lo;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] hi_m = 32'd0;
    logic [W-1:0] lo_m = 32'd0;

    md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: latency (0 = not accepted) and resulting HI/LO.
    task automatic model(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic [W-1:0] eh, output logic [W-1:0] el);
        longint p;
        int     sa;
        int     sb;
        lat = 0;
        eh  = hi_m;
        el  = lo_m;
        sa  = av;
        sb  = bv;
        case (op)
            2'd0: begin
                lat = ML;
                p   = longint'($signed(av)) * longint'($signed(bv));
                eh  = p[63:32];
                el  = p[31:0];
            end
            2'd1: begin
                lat = ML;
                p   = longint'({32'd0, av}) * longint'({32'd0, bv});
                eh  = p[63:32];
                el  = p[31:0];
            end
            2'd2: begin
`ifdef MD_DIV_EN
                lat = DL;
                if (bv == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = av;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    el = av;
                    eh = 32'd0;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
`endif
            end
            default: begin
`ifdef MD_DIV_EN
                lat = DL;
                if (bv == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = av;
                end else begin
                    el = av / bv;
                    eh = av % bv;
                end
`endif
            end
        endcase
    endtask

    // Issue one op from IDLE (caller sits at a negedge), optionally with a
    // same-cycle MTLO and a disturbing start+MTHI at busy sample 'poke'.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic mt_lo, input int poke);
        int           lat;
        int           nb;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        model(op, av, bv, lat, eh, el);
        if (lat == 0 && mt_lo) el = av;
        check("busy_in_start_cycle", busy, 0);
        start = 1'b1; md_op = op; a = av; b = bv; we_lo = mt_lo;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        nb = 0;
        for (int i = 0; i < lat; i++) begin
            if (busy) nb++;
            if (i == poke) begin
                start = 1'b1; md_op = 2'd1; a = 32'h1234; b = 32'd7; we_hi = 1'b1;
            end else begin
                start = 1'b0; we_hi = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; we_hi = 1'b0;
        check("busy_cycles", nb, lat);
        check("busy_after_op", busy, 0);
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
        hi_m = eh;
        lo_m = el;
    endtask

    // MTHI (sel_hi=1) or MTLO in IDLE; value visible one cycle later.
    task automatic mt_write(input logic sel_hi, input logic [W-1:0] val);
        we_hi = sel_hi; we_lo = ~sel_hi; a = val;
        @(posedge clk);
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        if (sel_hi) hi_m = val;
        else        lo_m = val;
        check("mt_hi", hi, hi_m);
        check("mt_lo", lo, lo_m);
    endtask

    function automatic logic [W-1:0] pick_b(input int sel);
        logic [W-1:0] v;
        case (sel)
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'($urandom_range(1, 9));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        rst = 1'b1; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        md_op = 2'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);

        // Directed cases.
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op(2'd3, 32'd7, 32'd2, 1'b0, -1);
        run_op(2'd2, 32'd5, 32'd0, 1'b0, -1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op(2'd0, 32'd1000, 32'hFFFF_FFFD, 1'b0, 1);
        mt_write(1'b1, 32'h1234);
        run_op(2'd0, 32'd3, 32'd4, 1'b1, -1);
        mt_write(1'b0, 32'hCAFE_0001);

        // Reset in busy cycle 4; result must never land.
`ifdef MD_DIV_EN
        md_op = 2'd2;
`else
        md_op = 2'd0;
`endif
        start = 1'b1; a = 32'h0000_0100; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        repeat (DL + 2) @(negedge clk);
        check("midrst_late_busy", busy, 0);
        check("midrst_late_hi", hi, 0);
        check("midrst_late_lo", lo, 0);

        // Randomised operations, back-to-back, with occasional MT writes.
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            run_op(rop, ra, pick_b($urandom_range(0, 5)), 1'($urandom_range(0, 4) == 0), -1);
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
